cpu_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared inter-CPU message bus. It sits above the per-CPU index managers. After reset it loads every CPU's index, then grants the bus to one requesting CPU at a time. It broadcasts that CPU's message and index on `ext_cpu_msg_in` / `ext_cpu_index` with `ext_next_cpu_q` so every index manager can renumber.

---
 rtl/cpu_bus_arbiter_if.sv | 80 ++++++++
 rtl/cpu_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter_if
//
// Purpose:
//   Bundles the request, broadcast and index-load signals exchanged between
//   the shared-bus arbiter and the per-CPU index managers.
//
// Signals (N = N_CPU, M = CPU_MSG_SIZE0+1, D = DATA_SIZE0+1):
//   clk_oe          phase flag; the arbiter only advances when it is 1
//   req     [N]     per-CPU level request
//   req_msg [N*M]   per-CPU message, CPU k in slice k
//   req_index [N*D] per-CPU current index, CPU k in slice k
//   done    [N]     per-CPU release strobe
//   grant   [N]     one-hot bus grant
//   bus_busy        bus owned or arbiter initialising
//   ext_cpu_index [D]  broadcast index
//   ext_cpu_msg_in [M] broadcast message
//   ext_next_cpu_q     broadcast-valid
//   cpu_index_set      index load strobe to all managers
//   cpu_index_init [N*D] load values, slice k holds k
//   timeout            forced-release pulse
//
// Modports:
//   master  the arbiter side (drives grant / broadcast / index load)
//   slave   the CPU / index-manager side
//
// Message and index widths come from the shared CPU_MSG_SIZE0 / DATA_SIZE0
// macros; defaults are supplied here when the surrounding build has none.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 31
`endif
`ifndef CPU_MSG_NONE
`define CPU_MSG_NONE 0
`endif
`ifndef CPU_R_START
`define CPU_R_START 1
`endif
`ifndef CPU_R_END
`define CPU_R_END 2
`endif

interface cpu_bus_arbiter_if #(
  parameter int N_CPU = 4
);
  localparam int MSG_W  = `CPU_MSG_SIZE0 + 1;
  localparam int DATA_W = `DATA_SIZE0 + 1;

  logic                      clk_oe;
  logic [N_CPU-1:0]          req;
  logic [N_CPU*MSG_W-1:0]    req_msg;
  logic [N_CPU*DATA_W-1:0]   req_index;
  logic [N_CPU-1:0]          done;
  logic [N_CPU-1:0]          grant;
  logic                      bus_busy;
  logic [DATA_W-1:0]         ext_cpu_index;
  logic [MSG_W-1:0]          ext_cpu_msg_in;
  logic                      ext_next_cpu_q;
  logic                      cpu_index_set;
  logic [N_CPU*DATA_W-1:0]   cpu_index_init;
  logic                      timeout;

  modport master (
    input  clk_oe, req, req_msg, req_index, done,
    output grant, bus_busy, ext_cpu_index, ext_cpu_msg_in, ext_next_cpu_q,
           cpu_index_set, cpu_index_init, timeout
  );

  modport slave (
    output clk_oe, req, req_msg, req_index, done,
    input  grant, bus_busy, ext_cpu_index, ext_cpu_msg_in, ext_next_cpu_q,
           cpu_index_set, cpu_index_init, timeout
  );

endinterface

// File: rtl/cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter
//
// Purpose:
//   Round-robin arbiter and sequencer for the shared inter-CPU message bus.
//   After reset it tells every index manager to load its initial index, then
//   grants the bus to one requesting CPU at a time, broadcasts that CPU's
//   message and index for one phase pair, and waits for the owner to release
//   the bus with done.
//
// Parameters:
//   N_CPU     number of CPUs arbitrated (2..16)
//   MAX_HOLD  hold-timeout limit in phase pairs (timeout build only)
//
// Ports:
//   clk   clock
//   rst   synchronous active-low reset, honoured on every clk edge
//   bus   cpu_bus_arbiter_if.master (request inputs, grant/broadcast outputs)
//
// Build option:
//   CPU_ARB_HOLD_TIMEOUT_EN  when defined, a bus owner that does not assert
//   done within MAX_HOLD hold phase pairs is forced off the bus and timeout
//   pulses for one phase pair. When undefined, HOLD waits indefinitely and
//   timeout is tied low.
//
// Timing model:
//   A phase pair is a clk edge with clk_oe==1 followed by one with clk_oe==0.
//   All state and outputs update only on clk_oe==1 edges so every broadcast
//   value is stable across the following clk_oe==0 edge, where the managers
//   act on it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module cpu_bus_arbiter #(
  parameter int N_CPU    = 4,
  parameter int MAX_HOLD = 255
) (
  input  logic              clk,
  input  logic              rst,
  cpu_bus_arbiter_if.master bus
);

  localparam int MSG_W  = `CPU_MSG_SIZE0 + 1;
  localparam int DATA_W = `DATA_SIZE0 + 1;
  localparam int PTR_W  = $clog2(N_CPU);

  // Elaboration-time guard on the supported configuration range.
  if (N_CPU < 2 || N_CPU > 16) begin : g_bad_n_cpu
    $error("cpu_bus_arbiter: N_CPU must be in 2..16");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("cpu_bus_arbiter: MAX_HOLD must be at least 1");
  end

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_GRANT,
    S_BCAST,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [DATA_W-1:0]  idx_q, idx_d;
  logic               done_seen_q, done_seen_d;

  logic [N_CPU-1:0]   grant_q, grant_d;
  logic               bus_busy_q, bus_busy_d;
  logic [DATA_W-1:0]  ext_index_q, ext_index_d;
  logic [MSG_W-1:0]   ext_msg_q, ext_msg_d;
  logic               bcast_q, bcast_d;
  logic               index_set_q, index_set_d;

`ifdef CPU_ARB_HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;
`endif

  logic [PTR_W-1:0]   scan_win;
  logic               scan_hit;
  logic [PTR_W:0]     cand;
  logic [MSG_W-1:0]   sel_msg;
  logic [DATA_W-1:0]  sel_idx;
  logic               win_done;
  logic [PTR_W-1:0]   next_ptr;

  // Round-robin pick: the first requester at or after rr_ptr, wrapping at
  // N_CPU. The candidate carries one extra bit so the wrap works for CPU
  // counts that are not a power of two.
  always_comb begin
    scan_hit = 1'b0;
    scan_win = '0;
    cand     = '0;
    for (int i = 0; i < N_CPU; i++) begin
      cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_CPU)) begin
        cand = cand - (PTR_W+1)'(N_CPU);
      end
      if (!scan_hit && bus.req[cand[PTR_W-1:0]]) begin
        scan_hit = 1'b1;
        scan_win = cand[PTR_W-1:0];
      end
    end
  end

  // Message and index of the CPU about to win, captured on the grant edge so
  // a requester that drops req afterwards cannot disturb the broadcast.
  always_comb begin
    sel_msg = '0;
    sel_idx = '0;
    for (int k = 0; k < N_CPU; k++) begin
      if (scan_win == PTR_W'(k)) begin
        sel_msg = bus.req_msg[k*MSG_W +: MSG_W];
        sel_idx = bus.req_index[k*DATA_W +: DATA_W];
      end
    end
  end

  // Only the current owner may release the bus.
  assign win_done = bus.done[win_q];

  // Next round-robin start point: one past the owner, wrapping to CPU0.
  assign next_ptr = (win_q == PTR_W'(N_CPU - 1)) ? '0 : win_q + 1'b1;

  // Next-state and next-output computation. Everything holds on clk_oe==0
  // edges; outputs are computed for the state being entered so they are
  // registered together with it.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    msg_d       = msg_q;
    idx_d       = idx_q;
    done_seen_d = done_seen_q;
    grant_d     = grant_q;
    bus_busy_d  = bus_busy_q;
    ext_index_d = ext_index_q;
    ext_msg_d   = ext_msg_q;
    bcast_d     = bcast_q;
    index_set_d = index_set_q;
`ifdef CPU_ARB_HOLD_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = timeout_q;
`endif

    if (bus.clk_oe) begin
`ifdef CPU_ARB_HOLD_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
      case (state_q)
        S_INIT: begin
          state_d     = S_IDLE;
          index_set_d = 1'b0;
          bus_busy_d  = 1'b0;
          grant_d     = '0;
          ext_msg_d   = MSG_W'(`CPU_MSG_NONE);
          bcast_d     = 1'b0;
        end

        S_IDLE: begin
          grant_d    = '0;
          bus_busy_d = 1'b0;
          ext_msg_d  = MSG_W'(`CPU_MSG_NONE);
          bcast_d    = 1'b0;
          if (scan_hit) begin
            state_d     = S_GRANT;
            win_d       = scan_win;
            msg_d       = sel_msg;
            idx_d       = sel_idx;
            done_seen_d = 1'b0;
            grant_d     = N_CPU'(1) << scan_win;
            bus_busy_d  = 1'b1;
          end
        end

        // A done from the owner arriving before HOLD is remembered so HOLD
        // only has to last a single phase pair.
        S_GRANT: begin
          state_d     = S_BCAST;
          ext_msg_d   = msg_q;
          ext_index_d = idx_q;
          bcast_d     = 1'b1;
          if (win_done) begin
            done_seen_d = 1'b1;
          end
        end

        S_BCAST: begin
          state_d   = S_HOLD;
          ext_msg_d = MSG_W'(`CPU_MSG_NONE);
          bcast_d   = 1'b0;
          if (win_done) begin
            done_seen_d = 1'b1;
          end
`ifdef CPU_ARB_HOLD_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end

        S_HOLD: begin
          if (win_done || done_seen_q) begin
            state_d     = S_RELEASE;
            grant_d     = '0;
            bus_busy_d  = 1'b0;
            rr_ptr_d    = next_ptr;
            done_seen_d = 1'b0;
          end
`ifdef CPU_ARB_HOLD_TIMEOUT_EN
          // The counter reaching MAX_HOLD marks the end of the last allowed
          // hold phase pair; the owner is then forced off the bus.
          else if (hold_cnt_q == HOLD_W'(MAX_HOLD - 1)) begin
            state_d     = S_RELEASE;
            grant_d     = '0;
            bus_busy_d  = 1'b0;
            rr_ptr_d    = next_ptr;
            done_seen_d = 1'b0;
            timeout_d   = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`endif
        end

        S_RELEASE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d     = S_INIT;
          index_set_d = 1'b1;
          bus_busy_d  = 1'b1;
          grant_d     = '0;
          bcast_d     = 1'b0;
          ext_msg_d   = MSG_W'(`CPU_MSG_NONE);
        end
      endcase
    end
  end

  // State and registered outputs. Reset wins on every edge regardless of
  // clk_oe, so a broadcast in flight is dropped cleanly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_INIT;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      msg_q       <= '0;
      idx_q       <= '0;
      done_seen_q <= 1'b0;
      grant_q     <= '0;
      bus_busy_q  <= 1'b1;
      ext_index_q <= '0;
      ext_msg_q   <= MSG_W'(`CPU_MSG_NONE);
      bcast_q     <= 1'b0;
      index_set_q <= 1'b1;
`ifdef CPU_ARB_HOLD_TIMEOUT_EN
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      msg_q       <= msg_d;
      idx_q       <= idx_d;
      done_seen_q <= done_seen_d;
      grant_q     <= grant_d;
      bus_busy_q  <= bus_busy_d;
      ext_index_q <= ext_index_d;
      ext_msg_q   <= ext_msg_d;
      bcast_q     <= bcast_d;
      index_set_q <= index_set_d;
`ifdef CPU_ARB_HOLD_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.grant          = grant_q;
  assign bus.bus_busy       = bus_busy_q;
  assign bus.ext_cpu_index  = ext_index_q;
  assign bus.ext_cpu_msg_in = ext_msg_q;
  assign bus.ext_next_cpu_q = bcast_q;
  assign bus.cpu_index_set  = index_set_q;

`ifdef CPU_ARB_HOLD_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  // Initial index of CPU k is k with the active bit (MSB) clear.
  for (genvar k = 0; k < N_CPU; k++) begin : g_index_init
    assign bus.cpu_index_init[k*DATA_W +: DATA_W] = DATA_W'(k);
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_arbiter
//
// Self-checking bench for cpu_bus_arbiter: a directed vector table, hand
// sequences for multi-cycle corner cases, and randomized traffic compared
// against a tenure-level reference model. Define CPU_ARB_HOLD_TIMEOUT_EN to
// also exercise the hold timeout with MAX_HOLD=8.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 31
`endif
`ifndef CPU_R_START
`define CPU_R_START 1
`endif
`ifndef CPU_R_END
`define CPU_R_END 2
`endif

module tb_cpu_bus_arbiter;

  localparam int N_CPU  = 4;
  localparam int MSG_W  = `CPU_MSG_SIZE0 + 1;
  localparam int DATA_W = `DATA_SIZE0 + 1;
`ifdef CPU_ARB_HOLD_TIMEOUT_EN
  localparam int MAX_HOLD = 8;
`else
  localparam int MAX_HOLD = 255;
`endif

  logic clk = 1'b0;
  logic rst;

  cpu_bus_arbiter_if #(.N_CPU(N_CPU)) bus ();

  cpu_bus_arbiter #(.N_CPU(N_CPU), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one bus tenure described by its owner and its age in
  // phase pairs since the grant, plus a one-pair cooldown after release.
  int                m_init;
  int                m_owner;
  int                m_age;
  int                m_early;
  int                m_held;
  int                m_cool;
  int                m_rr;
  int                m_to;
  logic [MSG_W-1:0]  m_msg;
  logic [DATA_W-1:0] m_idx;
  logic [DATA_W-1:0] m_last_idx;

  typedef struct packed {
    logic [N_CPU-1:0]  req;
    logic [N_CPU-1:0]  done;
    logic [N_CPU-1:0]  grant;
    logic              busy;
    logic              nxt;
    logic [MSG_W-1:0]  msg;
    logic [DATA_W-1:0] idx;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_init     = 1;
    m_owner    = -1;
    m_age      = 0;
    m_early    = 0;
    m_held     = 0;
    m_cool     = 0;
    m_rr       = 0;
    m_to       = 0;
    m_msg      = '0;
    m_idx      = '0;
    m_last_idx = '0;
  endtask

  task automatic releaseBus();
    m_rr    = (m_owner + 1) % N_CPU;
    m_owner = -1;
    m_cool  = 1;
  endtask

  // Advance the model by one phase pair using the inputs the DUT samples.
  task automatic modelStep();
    m_to = 0;
    if (m_init != 0) begin
      m_init = 0;
    end else if (m_cool != 0) begin
      m_cool = 0;
    end else if (m_owner < 0) begin
      if (bus.req != '0) begin
        for (int i = 0; i < N_CPU; i++) begin
          int c;
          c = (m_rr + i) % N_CPU;
          if (m_owner < 0 && bus.req[c]) m_owner = c;
        end
        m_age   = 1;
        m_early = 0;
        m_held  = 0;
        m_msg   = bus.req_msg[m_owner*MSG_W +: MSG_W];
        m_idx   = bus.req_index[m_owner*DATA_W +: DATA_W];
      end
    end else if (m_age < 3) begin
      if (bus.done[m_owner]) m_early = 1;
      m_age++;
      if (m_age == 2) m_last_idx = m_idx;
    end else begin
      if (m_early != 0 || bus.done[m_owner]) begin
        releaseBus();
      end else begin
`ifdef CPU_ARB_HOLD_TIMEOUT_EN
        m_held++;
        if (m_held == MAX_HOLD) begin
          m_to = 1;
          releaseBus();
        end
`endif
      end
    end
  endtask

  task automatic checkModel();
    logic [N_CPU-1:0] eg;
    logic             enx;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    enx = (m_owner >= 0 && m_age == 2);
    checkOutput("mdl_grant", bus.grant, eg);
    checkOutput("mdl_busy", bus.bus_busy, (m_init != 0 || m_owner >= 0));
    checkOutput("mdl_next", bus.ext_next_cpu_q, enx);
    checkOutput("mdl_msg", bus.ext_cpu_msg_in, enx ? m_msg : '0);
    checkOutput("mdl_index", bus.ext_cpu_index, m_last_idx);
    checkOutput("mdl_set", bus.cpu_index_set, (m_init != 0));
    checkOutput("mdl_timeout", bus.timeout, (m_to != 0));
  endtask

  // One full phase pair; outputs are compared after both edges so anything
  // moving on the clk_oe==0 edge is caught.
  task automatic stepPair();
    if (!rst) modelReset();
    else      modelStep();
    bus.clk_oe = 1'b1;
    @(posedge clk);
    #1;
    checkModel();
    bus.clk_oe = 1'b0;
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic applyStimulus(input logic [N_CPU-1:0] r, input logic [N_CPU-1:0] d);
    bus.req  = r;
    bus.done = d;
    stepPair();
  endtask

  task automatic doReset();
    rst = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    stepPair();
    checkOutput("rst_grant", bus.grant, '0);
    checkOutput("rst_busy", bus.bus_busy, 1'b1);
    checkOutput("rst_set", bus.cpu_index_set, 1'b1);
    checkOutput("rst_next", bus.ext_next_cpu_q, 1'b0);
    checkOutput("rst_index", bus.ext_cpu_index, '0);
    rst = 1'b1;
  endtask

  task automatic setDefaultMessages();
    for (int k = 0; k < N_CPU; k++) begin
      bus.req_msg[k*MSG_W +: MSG_W]     = (k == 2) ? MSG_W'(`CPU_R_START) : MSG_W'(`CPU_R_END);
      bus.req_index[k*DATA_W +: DATA_W] = DATA_W'(k);
    end
  endtask

  initial begin
    logic [N_CPU*DATA_W-1:0] exp_init;
    logic [N_CPU-1:0]        g;

    rst        = 1'b0;
    bus.clk_oe = 1'b0;
    bus.req    = '0;
    bus.done   = '0;
    setDefaultMessages();
    modelReset();

    vecs[0] = '{req: 4'b0000, done: 4'b0000, grant: 4'b0000, busy: 1'b0, nxt: 1'b0, msg: '0, idx: '0};
    vecs[1] = '{req: 4'b0100, done: 4'b0000, grant: 4'b0100, busy: 1'b1, nxt: 1'b0, msg: '0, idx: '0};
    vecs[2] = '{req: 4'b0000, done: 4'b0000, grant: 4'b0100, busy: 1'b1, nxt: 1'b1,
                msg: MSG_W'(`CPU_R_START), idx: DATA_W'(2)};
    vecs[3] = '{req: 4'b0000, done: 4'b0000, grant: 4'b0100, busy: 1'b1, nxt: 1'b0, msg: '0, idx: DATA_W'(2)};
    vecs[4] = '{req: 4'b0000, done: 4'b0100, grant: 4'b0000, busy: 1'b0, nxt: 1'b0, msg: '0, idx: DATA_W'(2)};
    vecs[5] = '{req: 4'b0000, done: 4'b0000, grant: 4'b0000, busy: 1'b0, nxt: 1'b0, msg: '0, idx: DATA_W'(2)};

    $display("[TB] reset and index load");
    doReset();
    exp_init = '0;
    for (int k = 0; k < N_CPU; k++) exp_init[k*DATA_W +: DATA_W] = DATA_W'(k);
    checkOutput("index_init", bus.cpu_index_init, exp_init);

    $display("[TB] directed vector table");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].done);
      checkOutput("tbl_grant", bus.grant, vecs[i].grant);
      checkOutput("tbl_busy", bus.bus_busy, vecs[i].busy);
      checkOutput("tbl_next", bus.ext_next_cpu_q, vecs[i].nxt);
      checkOutput("tbl_msg", bus.ext_cpu_msg_in, vecs[i].msg);
      checkOutput("tbl_index", bus.ext_cpu_index, vecs[i].idx);
      checkOutput("tbl_set", bus.cpu_index_set, 1'b0);
    end

    $display("[TB] round robin with all requesters");
    doReset();
    applyStimulus('0, '0);
    for (int t = 0; t < 5; t++) begin
      applyStimulus(4'b1111, '0);
      g = '0;
      g[t % N_CPU] = 1'b1;
      checkOutput("rr_order", bus.grant, g);
      applyStimulus(4'b1111, g);
      applyStimulus(4'b1111, '0);
      applyStimulus(4'b1111, '0);
      checkOutput("rr_release", bus.bus_busy, 1'b0);
      applyStimulus(4'b1111, '0);
    end

    $display("[TB] early done and foreign done");
    applyStimulus(4'b0010, '0);
    checkOutput("early_grant", bus.grant, 4'b0010);
    applyStimulus('0, 4'b0010);
    applyStimulus('0, '0);
    checkOutput("early_hold", bus.grant, 4'b0010);
    applyStimulus('0, '0);
    checkOutput("early_release", bus.grant, 4'b0000);
    applyStimulus('0, '0);
    applyStimulus(4'b0010, '0);
    applyStimulus('0, '0);
    applyStimulus('0, '0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, 4'b1000);
      checkOutput("foreign_done_grant", bus.grant, 4'b0010);
      checkOutput("foreign_done_busy", bus.bus_busy, 1'b1);
    end
    applyStimulus('0, 4'b0010);
    checkOutput("owner_done_release", bus.grant, 4'b0000);
    applyStimulus('0, '0);

    $display("[TB] reset during broadcast");
    applyStimulus(4'b0001, '0);
    modelStep();
    bus.req    = '0;
    bus.clk_oe = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bcast_before_rst", bus.ext_next_cpu_q, 1'b1);
    rst        = 1'b0;
    bus.clk_oe = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    checkOutput("rst_bcast_next", bus.ext_next_cpu_q, 1'b0);
    checkOutput("rst_bcast_grant", bus.grant, 4'b0000);
    checkOutput("rst_bcast_set", bus.cpu_index_set, 1'b1);
    checkOutput("rst_bcast_busy", bus.bus_busy, 1'b1);
    rst = 1'b1;
    applyStimulus('0, '0);
    checkOutput("rst_bcast_idle", bus.cpu_index_set, 1'b0);

`ifdef CPU_ARB_HOLD_TIMEOUT_EN
    $display("[TB] hold timeout");
    doReset();
    applyStimulus('0, '0);
    applyStimulus(4'b0100, '0);
    applyStimulus(4'b0101, '0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0101, '0);
      checkOutput("to_hold_grant", bus.grant, 4'b0100);
      checkOutput("to_hold_quiet", bus.timeout, 1'b0);
    end
    applyStimulus(4'b0101, '0);
    checkOutput("to_pulse", bus.timeout, 1'b1);
    checkOutput("to_release", bus.grant, 4'b0000);
    applyStimulus(4'b0101, '0);
    checkOutput("to_pulse_end", bus.timeout, 1'b0);
    applyStimulus(4'b0101, '0);
    checkOutput("to_next_grant", bus.grant, 4'b0001);
`endif

    $display("[TB] randomized traffic");
    doReset();
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < N_CPU; k++) begin
        bus.req_msg[k*MSG_W +: MSG_W]     = MSG_W'($urandom);
        bus.req_index[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      rst = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      applyStimulus(($urandom_range(0, 3) == 0) ? '0 : N_CPU'($urandom),
                    ($urandom_range(0, 2) == 0) ? N_CPU'($urandom) : '0);
      rst = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
